// File: rtl/line_fetch_scheduler_if.sv
// Framebuffer memory port shared by the line prefetcher and the pixel writer.
// The master side issues requests; the slave side grants and returns read data.
interface line_fetch_scheduler_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/line_fetch_scheduler.sv
// Arbitrates one framebuffer port between display line prefetch and a pixel
// writer; prefetched words land in a ping-pong line buffer bank.
module line_fetch_scheduler #(
  parameter int VACTIVE    = 272,
  parameter int VTOTAL     = 288,
  parameter int LINE_WORDS = 240,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  line_start_i,
  input  logic [8:0]            lin_i,
  input  logic                  wr_req_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  output logic                  wr_ack_o,
  line_fetch_scheduler_if.master mem,
  output logic                  lb_we_o,
  output logic                  lb_bank_o,
  output logic [7:0]            lb_addr_o,
  output logic [DATA_W-1:0]     lb_data_o,
  output logic                  underrun_o
);

  typedef enum logic [1:0] {
    IDLE,
    F_REQ,
    F_WAIT,
    W_REQ
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(LINE_WORDS - 1);

  state_e            state_q;
  logic [7:0]        idx_q;
  logic [8:0]        tgt_q;
  logic              pend_q;
  logic              pend_fetch_q;
  logic [8:0]        pend_tgt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              lb_we_q;
  logic              lb_bank_q;
  logic [7:0]        lb_addr_q;
  logic [DATA_W-1:0] lb_data_q;
  logic              underrun_q;

  logic              ls_fetch;
  logic [8:0]        ls_tgt;
  logic              new_pend;
  logic              new_fetch;
  logic [8:0]        new_tgt;

  function automatic logic [ADDR_W-1:0] fetch_addr(
    input logic [8:0] t,
    input logic [7:0] i
  );
    return ADDR_W'(BASE_ADDR)
         + ADDR_W'(t) * ADDR_W'(LINE_WORDS)
         + ADDR_W'(i);
  endfunction

  // Line after the current one, wrapping the last blanking line to line 0.
  always_comb begin
    ls_fetch = 1'b0;
    ls_tgt   = '0;
    if (lin_i == 9'(VTOTAL - 1)) begin
      ls_fetch = 1'b1;
      ls_tgt   = '0;
    end else if ({1'b0, lin_i} + 10'd1 < 10'(VACTIVE)) begin
      ls_fetch = 1'b1;
      ls_tgt   = lin_i + 9'd1;
    end
  end

  // A pulse arriving this very cycle supersedes any older pending one.
  assign new_pend  = line_start_i | pend_q;
  assign new_fetch = line_start_i ? ls_fetch : pend_fetch_q;
  assign new_tgt   = line_start_i ? ls_tgt : pend_tgt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tgt_q        <= '0;
      pend_q       <= 1'b0;
      pend_fetch_q <= 1'b0;
      pend_tgt_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      lb_we_q      <= 1'b0;
      lb_bank_q    <= 1'b0;
      lb_addr_q    <= '0;
      lb_data_q    <= '0;
      underrun_q   <= 1'b0;
    end else begin
      lb_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (line_start_i && ls_fetch) begin
            state_q    <= F_REQ;
            idx_q      <= '0;
            tgt_q      <= ls_tgt;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= fetch_addr(ls_tgt, 8'd0);
          end else if (wr_req_i) begin
            state_q     <= W_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_addr_i;
            mem_wdata_q <= wr_data_i;
          end
        end
        F_REQ, F_WAIT: begin
          if (line_start_i) begin
            underrun_q   <= 1'b1;
            pend_q       <= 1'b1;
            pend_fetch_q <= ls_fetch;
            pend_tgt_q   <= ls_tgt;
          end
          if (state_q == F_REQ) begin
            if (mem.mem_gnt_i) begin
              state_q   <= F_WAIT;
              mem_req_q <= 1'b0;
            end
          end else if (mem.mem_rvalid_i) begin
            lb_we_q   <= 1'b1;
            lb_bank_q <= tgt_q[0];
            lb_addr_q <= idx_q;
            lb_data_q <= mem.mem_rdata_i;
            if (new_pend) begin
              pend_q <= 1'b0;
              if (new_fetch) begin
                state_q    <= F_REQ;
                idx_q      <= '0;
                tgt_q      <= new_tgt;
                mem_req_q  <= 1'b1;
                mem_addr_q <= fetch_addr(new_tgt, 8'd0);
              end else begin
                state_q <= IDLE;
              end
            end else if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
            end else begin
              state_q    <= F_REQ;
              idx_q      <= idx_q + 8'd1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_addr(tgt_q, idx_q + 8'd1);
            end
          end
        end
        W_REQ: begin
          if (line_start_i) begin
            pend_q       <= 1'b1;
            pend_fetch_q <= ls_fetch;
            pend_tgt_q   <= ls_tgt;
          end
          if (mem.mem_gnt_i) begin
            pend_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
            if (new_pend && new_fetch) begin
              state_q    <= F_REQ;
              idx_q      <= '0;
              tgt_q      <= new_tgt;
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_addr(new_tgt, 8'd0);
            end
          end
        end
      endcase
    end
  end

  // The write grant is acknowledged in the cycle the memory accepts it.
  assign wr_ack_o        = mem_req_q & mem_we_q & mem.mem_gnt_i;
  assign mem.mem_req_o   = mem_req_q;
  assign mem.mem_we_o    = mem_we_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;
  assign lb_we_o         = lb_we_q;
  assign lb_bank_o       = lb_bank_q;
  assign lb_addr_o       = lb_addr_q;
  assign lb_data_o       = lb_data_q;
  assign underrun_o      = underrun_q;

endmodule
